// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the 5-stage pipeline hazard unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hazard_unit_pkg;

  // E-stage operand forwarding mux selects
  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUOutM

  // R15 is the PC. It is read through its own path and is never forwarded.
  localparam int REG_PC = 15;

  // Multi-cycle MUL sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    LAST = 2'b10
  } mul_state_t;

endpackage

// File: rtl/hazard_unit_mul_seq.sv
// MUL sequencer: holds a multi-cycle MUL in E, freezing F/D/E and bubbling M.
// Latency: outputs are combinational from the registered state.
// Backpressure: while BUSY the E/M boundary is stalled; mulstarte is ignored in LAST.
module hazard_unit_mul_seq
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mulstarte,
  output logic o_mulbusy,
  output logic o_stalle,
  output logic o_flushm
);

  // r_cnt holds the BUSY cycles still to go, including the current one. The
  // 2-cycle MUL loads zero and still spends its one mandatory BUSY cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_busy;

  // State and counter registers. Reset is asynchronous so a MUL in flight
  // is abandoned immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter update. BUSY leaves on its last counted cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mulstarte) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = LAST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      LAST: begin
        // The MUL moves to M on this edge; whatever enters E now is a new
        // instruction and is only examined once back in IDLE.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_mulbusy = w_busy;
  assign o_stalle  = w_busy;
  assign o_flushm  = w_busy;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, load-use / branch / MUL stalls and flushes.
// Latency: all outputs combinational from inputs and MUL sequencer state.
// Backpressure: stalls hold F/D(/E); stall in E overrides a load-use flush of E.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1d,
  input  logic [ADDR_W-1:0] ra2d,
  input  logic [ADDR_W-1:0] ra1e,
  input  logic [ADDR_W-1:0] ra2e,
  input  logic [ADDR_W-1:0] wa3e,
  input  logic [ADDR_W-1:0] wa3m,
  input  logic [ADDR_W-1:0] wa3w,
  input  logic              regwritee,
  input  logic              regwritem,
  input  logic              regwritew,
  input  logic              memtoregE,
  input  logic              branchtakene,
  input  logic              mulstarte,
  output logic [1:0]        forwardae,
  output logic [1:0]        forwardbe,
  output logic              stallf,
  output logic              stalld,
  output logic              stalle,
  output logic              flushd,
  output logic              flushe,
  output logic              flushm,
  output logic              mulbusy
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);

  logic w_ldrstall;
  logic w_mulbusy;
  logic w_mul_stalle;
  logic w_mul_flushm;

  // M is the younger result, so it wins over W; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] ra,
                                         input logic [ADDR_W-1:0] wam,
                                         input logic [ADDR_W-1:0] waw,
                                         input logic              rwm,
                                         input logic              rww);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != PC_ADDR) begin
      if (rwm && (wam == ra))      sel = FWD_M;
      else if (rww && (waw == ra)) sel = FWD_W;
    end
    return sel;
  endfunction

  hazard_unit_mul_seq #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_mul_seq (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_mulstarte (mulstarte),
    .o_mulbusy   (w_mulbusy),
    .o_stalle    (w_mul_stalle),
    .o_flushm    (w_mul_flushm)
  );

  // Operand forwarding selects for both E-stage sources.
  always_comb begin
    forwardae = fwd_sel(ra1e, wa3m, wa3w, regwritem, regwritew);
    forwardbe = fwd_sel(ra2e, wa3m, wa3w, regwritem, regwritew);
  end

  // Stall/flush combination. A stalled E must keep its MUL, so the load-use
  // bubble is suppressed there; a taken branch always flushes D and E.
  always_comb begin
    w_ldrstall = memtoregE & regwritee & ((ra1d == wa3e) | (ra2d == wa3e));
    stallf     = w_ldrstall | w_mulbusy;
    stalld     = w_ldrstall | w_mulbusy;
    stalle     = w_mul_stalle;
    flushd     = branchtakene;
    flushe     = branchtakene | (w_ldrstall & ~w_mul_stalle);
    flushm     = w_mul_flushm;
    mulbusy    = w_mulbusy;
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic       regwritee, regwritem, regwritew, memtoregE, branchtakene;
  logic       mulstart4, mulstart2;

  logic [1:0] fae4, fbe4, fae2, fbe2;
  logic       stallf4, stalld4, stalle4, flushd4, flushe4, flushm4, mulbusy4;
  logic       stallf2, stalld2, stalle2, flushd2, flushe2, flushm2, mulbusy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.ADDR_W(4), .MUL_LAT(4), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
    .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w), .regwritee(regwritee), .regwritem(regwritem),
    .regwritew(regwritew), .memtoregE(memtoregE), .branchtakene(branchtakene),
    .mulstarte(mulstart4), .forwardae(fae4), .forwardbe(fbe4), .stallf(stallf4),
    .stalld(stalld4), .stalle(stalle4), .flushd(flushd4), .flushe(flushe4),
    .flushm(flushm4), .mulbusy(mulbusy4)
  );

  hazard_unit #(.ADDR_W(4), .MUL_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
    .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w), .regwritee(regwritee), .regwritem(regwritem),
    .regwritew(regwritew), .memtoregE(memtoregE), .branchtakene(branchtakene),
    .mulstarte(mulstart2), .forwardae(fae2), .forwardbe(fbe2), .stallf(stallf2),
    .stalld(stalld2), .stalle(stalle2), .flushd(flushd2), .flushe(flushe2),
    .flushm(flushm2), .mulbusy(mulbusy2)
  );

  // {mulbusy, stallf, stalld, stalle, flushm}
  wire [4:0] mulv4 = {mulbusy4, stallf4, stalld4, stalle4, flushm4};
  wire [4:0] mulv2 = {mulbusy2, stallf2, stalld2, stalle2, flushm2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ra1d = 4'd0; ra2d = 4'd0; ra1e = 4'd0; ra2e = 4'd0;
    wa3e = 4'd0; wa3m = 4'd0; wa3w = 4'd0;
    regwritee = 1'b0; regwritem = 1'b0; regwritew = 1'b0;
    memtoregE = 1'b0; branchtakene = 1'b0;
    mulstart4 = 1'b0; mulstart2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    mulstart4 = 1'b1;
    mulstart2 = 1'b1;
    #2;
    n_checks++;
    if (mulv4 !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mulv4: got %b want 00000", mulv4);
    end
    tick();
    n_checks++;
    if ({mulbusy4, mulbusy2, stalle4, flushm2} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_held_edge: got %b want 0000", {mulbusy4, mulbusy2, stalle4, flushm2});
    end
    regwritem = 1'b1; wa3m = 4'd3; ra1e = 4'd3;
    #1;
    n_checks++;
    if (fae4 !== 2'b10) begin
      n_fail++; $display("FAIL reset_fwd_comb: got %b want 10", fae4);
    end
    clear_inputs();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mulv4, mulv2} !== 10'b0) begin
      n_fail++; $display("FAIL reset_release: got %b want 0", {mulv4, mulv2});
    end
  endtask

  task automatic test_forwarding();
    tick();
    clear_inputs();
    regwritem = 1'b1; wa3m = 4'd3; ra1e = 4'd3; regwritew = 1'b1; wa3w = 4'd3;
    #1;
    n_checks++;
    if (fae4 !== 2'b10) begin
      n_fail++; $display("FAIL fwd_m_priority: got %b want 10", fae4);
    end
    regwritem = 1'b0;
    #1;
    n_checks++;
    if (fae4 !== 2'b01) begin
      n_fail++; $display("FAIL fwd_w: got %b want 01", fae4);
    end
    regwritem = 1'b1; ra1e = 4'd15; wa3m = 4'd15; wa3w = 4'd15;
    #1;
    n_checks++;
    if (fae4 !== 2'b00) begin
      n_fail++; $display("FAIL fwd_pc_never: got %b want 00", fae4);
    end
    clear_inputs();
    ra1e = 4'd4; ra2e = 4'd7; regwritew = 1'b1; wa3w = 4'd7; regwritem = 1'b1; wa3m = 4'd9;
    #1;
    n_checks++;
    if ({fae4, fbe4} !== 4'b0001) begin
      n_fail++; $display("FAIL fwd_b_w: got %b want 0001", {fae4, fbe4});
    end
    wa3m = 4'd7; regwritew = 1'b0;
    #1;
    n_checks++;
    if ({fae4, fbe4} !== 4'b0010) begin
      n_fail++; $display("FAIL fwd_b_m: got %b want 0010", {fae4, fbe4});
    end
  endtask

  task automatic test_load_use();
    tick();
    clear_inputs();
    memtoregE = 1'b1; regwritee = 1'b1; wa3e = 4'd5; ra2d = 4'd5; ra1d = 4'd2;
    #1;
    n_checks++;
    if ({stallf4, stalld4, flushe4, stalle4, flushd4} !== 5'b11100) begin
      n_fail++; $display("FAIL ldr_stall: got %b want 11100", {stallf4, stalld4, flushe4, stalle4, flushd4});
    end
    // Next cycle the bubble sits in E; the load has moved on.
    tick();
    clear_inputs();
    ra2d = 4'd5;
    #1;
    n_checks++;
    if ({stallf4, stalld4, flushe4} !== 3'b000) begin
      n_fail++; $display("FAIL ldr_one_cycle: got %b want 000", {stallf4, stalld4, flushe4});
    end
    memtoregE = 1'b1; regwritee = 1'b0; wa3e = 4'd5;
    #1;
    n_checks++;
    if ({stallf4, stalld4, flushe4} !== 3'b000) begin
      n_fail++; $display("FAIL ldr_no_write: got %b want 000", {stallf4, stalld4, flushe4});
    end
  endtask

  task automatic test_branch();
    tick();
    clear_inputs();
    branchtakene = 1'b1;
    regwritem = 1'b1; wa3m = 4'd6; ra1e = 4'd6;
    #1;
    n_checks++;
    if ({flushd4, flushe4, stallf4, stalld4, stalle4, fae4} !== 7'b1100010) begin
      n_fail++; $display("FAIL branch_flush: got %b want 1100010", {flushd4, flushe4, stallf4, stalld4, stalle4, fae4});
    end
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_mul4();
    logic [4:0] exp_v [5] = '{5'b00000, 5'b11111, 5'b11111, 5'b00000, 5'b00000};
    tick();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      mulstart4 = (c == 0) || (c == 3);  // start, then a pulse in LAST that must be ignored
      #1;
      n_checks++;
      if (mulv4 !== exp_v[c]) begin
        n_fail++; $display("FAIL mul4_cycle%0d: got %b want %b", c, mulv4, exp_v[c]);
      end
    end
    mulstart4 = 1'b0;
  endtask

  task automatic test_mul2();
    logic [4:0] exp_v [4] = '{5'b00000, 5'b11111, 5'b00000, 5'b00000};
    tick();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      mulstart2 = (c == 0) || (c == 2);  // pulse in LAST must be ignored
      #1;
      n_checks++;
      if (mulv2 !== exp_v[c]) begin
        n_fail++; $display("FAIL mul2_cycle%0d: got %b want %b", c, mulv2, exp_v[c]);
      end
    end
    mulstart2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v [9] = '{5'b00000, 5'b11111, 5'b11111, 5'b00000, 5'b00000,
                              5'b11111, 5'b11111, 5'b00000, 5'b00000};
    tick();
    clear_inputs();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      clear_inputs();
      mulstart4 = (c == 0) || (c == 3) || (c == 4);
      if (c == 2) begin
        memtoregE = 1'b1; regwritee = 1'b1; wa3e = 4'd5; ra1d = 4'd5;
      end
      if (c == 6) branchtakene = 1'b1;
      #1;
      n_checks++;
      if (mulv4 !== exp_v[c]) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %b want %b", c, mulv4, exp_v[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (flushe4 !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ldr_in_busy_flushe: got %b want 0", flushe4);
        end
      end
      if (c == 6) begin
        n_checks++;
        if ({flushd4, flushe4} !== 2'b11) begin
          n_fail++; $display("FAIL b2b_branch_in_busy: got %b want 11", {flushd4, flushe4});
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    logic [4:0] exp_v [5] = '{5'b00000, 5'b11111, 5'b11111, 5'b00000, 5'b00000};
    tick();
    clear_inputs();
    mulstart4 = 1'b1;
    tick();
    mulstart4 = 1'b0;
    tick();
    #1;
    n_checks++;
    if (mulv4 !== 5'b11111) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b want 11111", mulv4);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mulv4 !== 5'b00000) begin
      n_fail++; $display("FAIL rst_mid_async: got %b want 00000", mulv4);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      mulstart4 = (c == 0);
      #1;
      n_checks++;
      if (mulv4 !== exp_v[c]) begin
        n_fail++; $display("FAIL rst_fresh_cycle%0d: got %b want %b", c, mulv4, exp_v[c]);
      end
    end
    mulstart4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mul4();
    test_mul2();
    test_back_to_back();
    test_reset_mid_busy();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
